// File: rtl/traffic_mon_pkg.sv
// Shared phase codes, fault codes and legal phase-transition table for the lamp monitor.
// Pure declarations; no latency or flow-control implications.
package traffic_mon_pkg;

  typedef enum logic [2:0] {
    PH_AR    = 3'd0,
    PH_G1    = 3'd1,
    PH_Y1    = 3'd2,
    PH_G2    = 3'd3,
    PH_Y2    = 3'd4,
    PH_FLASH = 3'd5,
    PH_BAD   = 3'd7
  } phase_t;

  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_CONFLICT  = 3'd1,
    FC_ILLEGAL   = 3'd2,
    FC_SEQ       = 3'd3,
    FC_SHORT_YLW = 3'd4,
    FC_TIMEOUT   = 3'd5
  } fcode_t;

  // Lamp vectors ordered {grn1, ylw1, red1, grn2, ylw2, red2}.
  localparam logic [5:0] LAMPS_AR = 6'b001_001;
  localparam logic [5:0] LAMPS_G1 = 6'b100_001;
  localparam logic [5:0] LAMPS_Y1 = 6'b010_001;
  localparam logic [5:0] LAMPS_G2 = 6'b001_100;
  localparam logic [5:0] LAMPS_Y2 = 6'b001_010;

  // Row = current phase, bit = destination phase. FLASH is only ever decoded
  // while flash mode is on, so allowing it as a destination is safe.
  // BAD may only stay BAD; every exit from it is a sequence error.
  localparam logic [7:0][7:0] LEGAL_TBL = {
    8'h80,  // BAD   -> BAD
    8'h00,  // unused code
    8'h21,  // FLASH -> FLASH, AR
    8'h33,  // Y2    -> Y2, AR, G1, FLASH
    8'h38,  // G2    -> G2, Y2, FLASH
    8'h2D,  // Y1    -> Y1, AR, G2, FLASH
    8'h26,  // G1    -> G1, Y1, FLASH
    8'h2B   // AR    -> AR, G1, G2, FLASH
  };

  function automatic logic is_legal(input phase_t from, input phase_t to);
    return LEGAL_TBL[from][to];
  endfunction

  function automatic logic is_timed(input phase_t ph);
    return ph inside {PH_G1, PH_Y1, PH_G2, PH_Y2};
  endfunction

  function automatic logic is_yellow(input phase_t ph);
    return ph inside {PH_Y1, PH_Y2};
  endfunction

  function automatic fcode_t pick_fault(input logic conflict, input logic illegal,
                                        input logic seq_err, input logic short_ylw,
                                        input logic timeout);
    if (conflict)  return FC_CONFLICT;
    if (illegal)   return FC_ILLEGAL;
    if (seq_err)   return FC_SEQ;
    if (short_ylw) return FC_SHORT_YLW;
    if (timeout)   return FC_TIMEOUT;
    return FC_NONE;
  endfunction

endpackage

// File: rtl/lamp_decode.sv
// Maps six lamp drives plus flash-mode to a phase code and conflict/illegal flags.
// Purely combinational; no backpressure.
module lamp_decode
  import traffic_mon_pkg::*;
(
  input  logic       grn1,
  input  logic       ylw1,
  input  logic       red1,
  input  logic       grn2,
  input  logic       ylw2,
  input  logic       red2,
  input  logic       fm,
  output logic [2:0] phase,
  output logic       conflict,
  output logic       illegal
);

  logic [5:0] vec;
  phase_t     ph;

  assign vec = {grn1, ylw1, red1, grn2, ylw2, red2};

  always_comb begin
    ph = PH_BAD;
    if (fm && !grn1 && !grn2) begin
      ph = PH_FLASH;
    end else begin
      case (vec)
        LAMPS_AR: ph = PH_AR;
        LAMPS_G1: ph = PH_G1;
        LAMPS_Y1: ph = PH_Y1;
        LAMPS_G2: ph = PH_G2;
        LAMPS_Y2: ph = PH_Y2;
        default:  ph = PH_BAD;
      endcase
    end
  end

  // Any "go" lamp (green or yellow) lit on both approaches at once.
  assign conflict = (grn1 | ylw1) & (grn2 | ylw2);
  assign illegal  = (ph == PH_BAD) & ~conflict;
  assign phase    = ph;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Watches intersection lamp drives, tracks phase/dwell and latches the first fault.
// Latency 1 cycle from lamp sample to outputs; no backpressure, samples every cycle.
module traffic_lamp_monitor
  import traffic_mon_pkg::*;
#(
  parameter int MIN_YLW   = 3,
  parameter int MAX_DWELL = 200,
  parameter int DWELL_W   = 8
) (
  input  logic               CK,
  input  logic               CLR,
  input  logic               GRN1,
  input  logic               YLW1,
  input  logic               RED1,
  input  logic               GRN2,
  input  logic               YLW2,
  input  logic               RED2,
  input  logic               FM,
  output logic [2:0]         PHASE,
  output logic [DWELL_W-1:0] DWELL,
  output logic               CHG,
  output logic               FAULT,
  output logic [2:0]         FCODE
);

  // A yellow that leaves with dwell below this held fewer than MIN_YLW samples.
  localparam logic [DWELL_W-1:0] YLW_LIM = (MIN_YLW > 0) ? DWELL_W'(MIN_YLW - 1) : '0;
  localparam logic [DWELL_W-1:0] MAX_DW  = DWELL_W'(MAX_DWELL);

  logic [2:0]         dec_raw;
  phase_t             dec_phase;
  logic               conflict;
  logic               illegal;

  phase_t             phase_q,  phase_d;
  logic [DWELL_W-1:0] dwell_q,  dwell_d;
  logic               chg_q,    chg_d;
  logic               fault_q,  fault_d;
  fcode_t             fcode_q,  fcode_d;

  logic               changed;
  logic               seq_err;
  logic               short_ylw;
  logic               timeout;
  fcode_t             new_fault;

  lamp_decode u_decode (
    .grn1     (GRN1),
    .ylw1     (YLW1),
    .red1     (RED1),
    .grn2     (GRN2),
    .ylw2     (YLW2),
    .red2     (RED2),
    .fm       (FM),
    .phase    (dec_raw),
    .conflict (conflict),
    .illegal  (illegal)
  );

  assign dec_phase = phase_t'(dec_raw);

  // phase_q holds the decode of the last sampled vector; reset puts it at AR so
  // the first sample after reset is judged as a transition out of AR.
  always_ff @(posedge CK) begin
    if (CLR) begin
      phase_q <= PH_AR;
      dwell_q <= '0;
      chg_q   <= 1'b0;
      fault_q <= 1'b0;
      fcode_q <= FC_NONE;
    end else begin
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      chg_q   <= chg_d;
      fault_q <= fault_d;
      fcode_q <= fcode_d;
    end
  end

  always_comb begin
    changed   = (dec_phase != phase_q);
    seq_err   = changed && !is_legal(phase_q, dec_phase);
    short_ylw = changed && is_yellow(phase_q) && (dwell_q < YLW_LIM);
    // A phase change on the cycle the limit is reached ends the phase in time.
    timeout   = !changed && is_timed(phase_q) && (dwell_q == MAX_DW);
    new_fault = pick_fault(conflict, illegal, seq_err, short_ylw, timeout);

    phase_d = dec_phase;
    chg_d   = changed;
    if (changed) begin
      dwell_d = '0;
    end else if (&dwell_q) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
    end

    fault_d = fault_q | (new_fault != FC_NONE);
    fcode_d = fault_q ? fcode_q : new_fault;
  end

  always_comb begin
    PHASE = phase_q;
    DWELL = dwell_q;
    CHG   = chg_q;
    FAULT = fault_q;
    FCODE = fcode_q;
  end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed vector bench for traffic_lamp_monitor with default parameters.
module tb_traffic_lamp_monitor;

  localparam logic [5:0] L_AR  = 6'b001_001;
  localparam logic [5:0] L_G1  = 6'b100_001;
  localparam logic [5:0] L_Y1  = 6'b010_001;
  localparam logic [5:0] L_G2  = 6'b001_100;
  localparam logic [5:0] L_Y2  = 6'b001_010;
  localparam logic [5:0] L_OFF = 6'b000_000;
  localparam logic [5:0] L_YA  = 6'b010_000;
  localparam logic [5:0] L_YB  = 6'b000_010;
  localparam logic [5:0] L_GGR = 6'b100_101;
  localparam logic [5:0] L_GG  = 6'b100_100;
  localparam logic [5:0] L_YY  = 6'b010_010;

  typedef struct {
    logic       clr;
    logic [5:0] lamps;
    logic       fm;
    int         n;
    logic [2:0] ph;
    logic [7:0] dw;
    logic       chg;
    logic       flt;
    logic [2:0] fc;
  } vec_t;

  logic       ck;
  logic       clr;
  logic       grn1, ylw1, red1, grn2, ylw2, red2;
  logic       fm;
  logic [2:0] phase;
  logic [7:0] dwell;
  logic       chg;
  logic       fault;
  logic [2:0] fcode;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  traffic_lamp_monitor #(
    .MIN_YLW   (3),
    .MAX_DWELL (200),
    .DWELL_W   (8)
  ) dut (
    .CK    (ck),
    .CLR   (clr),
    .GRN1  (grn1),
    .YLW1  (ylw1),
    .RED1  (red1),
    .GRN2  (grn2),
    .YLW2  (ylw2),
    .RED2  (red2),
    .FM    (fm),
    .PHASE (phase),
    .DWELL (dwell),
    .CHG   (chg),
    .FAULT (fault),
    .FCODE (fcode)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  function automatic vec_t row(input int c, input int l, input int f, input int n,
                               input int p, input int d, input int ch, input int ft,
                               input int fc);
    vec_t r;
    r.clr   = 1'(c);
    r.lamps = 6'(l);
    r.fm    = 1'(f);
    r.n     = n;
    r.ph    = 3'(p);
    r.dw    = 8'(d);
    r.chg   = 1'(ch);
    r.flt   = 1'(ft);
    r.fc    = 3'(fc);
    return r;
  endfunction

  // Drive one sample, let it be captured, then settle away from the edge.
  task automatic apply(input logic c, input logic [5:0] l, input logic f);
    clr = c;
    {grn1, ylw1, red1, grn2, ylw2, red2} = l;
    fm = f;
    @(posedge ck);
    #1;
  endtask

  task automatic check(input string name, input int ep, input int ed, input int ec,
                       input int ef, input int efc);
    n_checks++;
    if (phase !== 3'(ep) || dwell !== 8'(ed) || chg !== 1'(ec) ||
        fault !== 1'(ef) || fcode !== 3'(efc)) begin
      n_fail++;
      $display("FAIL %s: got phase=%0d dwell=%0d chg=%0b fault=%0b fcode=%0d, want phase=%0d dwell=%0d chg=%0d fault=%0d fcode=%0d",
               name, phase, dwell, chg, fault, fcode, ep, ed, ec, ef, efc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1;
    {grn1, ylw1, red1, grn2, ylw2, red2} = L_AR;
    fm = 1'b0;

    //               clr lamps  fm  n  ph  dw chg flt fc
    tbl.push_back(row(1, L_AR,  0,  2, 0,  0, 0,  0,  0));
    tbl.push_back(row(0, L_G1,  0,  1, 1,  0, 1,  0,  0));
    tbl.push_back(row(0, L_G1,  0,  9, 1,  9, 0,  0,  0));
    tbl.push_back(row(0, L_Y1,  0,  1, 2,  0, 1,  0,  0));
    tbl.push_back(row(0, L_Y1,  0,  2, 2,  2, 0,  0,  0));
    tbl.push_back(row(0, L_AR,  0,  1, 0,  0, 1,  0,  0));
    tbl.push_back(row(0, L_AR,  0,  1, 0,  1, 0,  0,  0));
    tbl.push_back(row(0, L_G2,  0,  1, 3,  0, 1,  0,  0));
    tbl.push_back(row(0, L_G2,  0,  9, 3,  9, 0,  0,  0));
    tbl.push_back(row(0, L_Y2,  0,  1, 4,  0, 1,  0,  0));
    tbl.push_back(row(0, L_Y2,  0,  2, 4,  2, 0,  0,  0));
    tbl.push_back(row(0, L_G1,  0,  1, 1,  0, 1,  0,  0));
    // green conflict mid-G1, then fault persists through legal phases
    tbl.push_back(row(0, L_G1,  0,  2, 1,  2, 0,  0,  0));
    tbl.push_back(row(0, L_GGR, 0,  1, 7,  0, 1,  1,  1));
    tbl.push_back(row(0, L_G1,  0,  1, 1,  0, 1,  1,  1));
    tbl.push_back(row(0, L_Y1,  0,  3, 2,  2, 0,  1,  1));
    tbl.push_back(row(0, L_AR,  0,  1, 0,  0, 1,  1,  1));
    tbl.push_back(row(1, L_AR,  0,  1, 0,  0, 0,  0,  0));
    // G1 straight to G2
    tbl.push_back(row(0, L_G1,  0,  1, 1,  0, 1,  0,  0));
    tbl.push_back(row(0, L_G2,  0,  1, 3,  0, 1,  1,  3));
    tbl.push_back(row(1, L_AR,  0,  1, 0,  0, 0,  0,  0));
    // yellow held only two samples
    tbl.push_back(row(0, L_G1,  0,  2, 1,  1, 0,  0,  0));
    tbl.push_back(row(0, L_Y1,  0,  2, 2,  1, 0,  0,  0));
    tbl.push_back(row(0, L_AR,  0,  1, 0,  0, 1,  1,  4));
    tbl.push_back(row(1, L_AR,  0,  1, 0,  0, 0,  0,  0));
    // flash mode with alternating yellows, back to AR, then dark without flash
    tbl.push_back(row(0, L_OFF, 1,  1, 5,  0, 1,  0,  0));
    tbl.push_back(row(0, L_YA,  1,  1, 5,  1, 0,  0,  0));
    tbl.push_back(row(0, L_OFF, 1,  1, 5,  2, 0,  0,  0));
    tbl.push_back(row(0, L_YB,  1,  1, 5,  3, 0,  0,  0));
    tbl.push_back(row(0, L_AR,  0,  1, 0,  0, 1,  0,  0));
    tbl.push_back(row(0, L_OFF, 0,  1, 7,  0, 1,  1,  2));
    tbl.push_back(row(1, L_AR,  0,  1, 0,  0, 0,  0,  0));
    // both greens in flash mode is still a conflict
    tbl.push_back(row(0, L_GG,  1,  1, 7,  0, 1,  1,  1));
    tbl.push_back(row(1, L_AR,  0,  1, 0,  0, 0,  0,  0));
    // FLASH may only exit to AR
    tbl.push_back(row(0, L_OFF, 1,  1, 5,  0, 1,  0,  0));
    tbl.push_back(row(0, L_G1,  0,  1, 1,  0, 1,  1,  3));
    tbl.push_back(row(1, L_AR,  0,  1, 0,  0, 0,  0,  0));
    // Y1 back to G1 after one sample: sequence outranks short yellow
    tbl.push_back(row(0, L_G1,  0,  1, 1,  0, 1,  0,  0));
    tbl.push_back(row(0, L_Y1,  0,  1, 2,  0, 1,  0,  0));
    tbl.push_back(row(0, L_G1,  0,  1, 1,  0, 1,  1,  3));
    tbl.push_back(row(1, L_AR,  0,  1, 0,  0, 0,  0,  0));
    // both yellows without flash mode
    tbl.push_back(row(0, L_YY,  0,  1, 7,  0, 1,  1,  1));
    tbl.push_back(row(1, L_AR,  0,  1, 0,  0, 0,  0,  0));

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) apply(tbl[i].clr, tbl[i].lamps, tbl[i].fm);
      check($sformatf("row%0d", i), tbl[i].ph, tbl[i].dw, tbl[i].chg, tbl[i].flt, tbl[i].fc);
    end

    // G2 held past the dwell limit: fault lands the sample after DWELL shows 200
    repeat (201) apply(1'b0, L_G2, 1'b0);
    check("g2_dwell_200", 3, 200, 0, 0, 0);
    apply(1'b0, L_G2, 1'b0);
    check("g2_timeout", 3, 201, 0, 1, 5);
    apply(1'b0, L_Y2, 1'b0);
    check("track_after_timeout", 4, 0, 1, 1, 5);
    apply(1'b1, L_AR, 1'b0);

    // leaving G1 exactly when DWELL reaches the limit is not a timeout
    repeat (201) apply(1'b0, L_G1, 1'b0);
    check("g1_dwell_200", 1, 200, 0, 0, 0);
    apply(1'b0, L_Y1, 1'b0);
    check("change_at_limit", 2, 0, 1, 0, 0);
    apply(1'b1, L_AR, 1'b0);

    // AR is exempt from timeout; DWELL saturates instead of wrapping
    repeat (255) apply(1'b0, L_AR, 1'b0);
    check("ar_dwell_255", 0, 255, 0, 0, 0);
    repeat (45) apply(1'b0, L_AR, 1'b0);
    check("ar_dwell_sat", 0, 255, 0, 0, 0);
    apply(1'b1, L_AR, 1'b0);

    // CLR mid-yellow, coinciding with a conflicting vector
    repeat (3) apply(1'b0, L_G1, 1'b0);
    repeat (2) apply(1'b0, L_Y1, 1'b0);
    check("y1_dwell_1", 2, 1, 0, 0, 0);
    apply(1'b1, L_GGR, 1'b0);
    check("clr_override", 0, 0, 0, 0, 0);
    apply(1'b0, L_G1, 1'b0);
    check("g1_after_clr", 1, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_monitor.md
TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

Interface
REQ-001 SHALL have parameter MIN_YLW, default 3: minimum cycles a yellow phase must hold.
REQ-002 SHALL have parameter MAX_DWELL, default 200: maximum cycles in any green or yellow phase.
REQ-003 SHALL have parameter DWELL_W, default 8: dwell counter width.
REQ-004 SHALL have port CK, input, 1: clock; all state updates on rising edge.
REQ-005 SHALL have port CLR, input, 1: reset; one clock, synchronous, active-high (already decided).
REQ-006 SHALL have ports GRN1, YLW1, RED1, GRN2, YLW2, RED2, inputs, 1 each: observed lamp drives, direction 1 and direction 2.
REQ-007 SHALL have port FM, input, 1: flash mode; the controller is permitted to flash.
REQ-008 SHALL have port PHASE, output, 3: decoded phase: 0 AR (all red), 1 G1, 2 Y1, 3 G2, 4 Y2, 5 FLASH, 7 BAD.
REQ-009 SHALL have port DWELL, output, DWELL_W: cycles elapsed in the current PHASE.
REQ-010 SHALL have port CHG, output, 1: one-cycle pulse when PHASE changes.
REQ-011 SHALL have port FAULT, output, 1: sticky fault flag.
REQ-012 SHALL have port FCODE, output, 3: first fault: 0 none, 1 conflict, 2 illegal, 3 sequence, 4 short yellow, 5 timeout.

Function
REQ-013 Decode SHALL be: G1 = GRN1 only on side 1 and RED2 only on side 2; Y1 = YLW1 with RED2; G2 = RED1 with GRN2; Y2 = RED1 with YLW2; AR = RED1 with RED2. Any other vector is BAD.
REQ-014 When FM=1, any vector with GRN1=GRN2=0 SHALL decode as FLASH.
REQ-015 PHASE, DWELL, CHG, FAULT and FCODE SHALL reflect the lamp vector sampled at the previous edge; latency is exactly 1 cycle.
REQ-016 Legal transitions: AR->G1|G2; G1->Y1; Y1->AR|G2; G2->Y2; Y2->AR|G1; any->FLASH only while FM=1; FLASH->AR only.
REQ-017 An unchanged phase SHALL be legal.
REQ-018 Conflict SHALL be raised when either GRN or YLW is lit on both directions at the same time, regardless of FM.
REQ-019 Illegal SHALL be raised when a vector decodes to BAD and conflict is not true.
REQ-020 Sequence SHALL be raised on a transition not listed in REQ-016, including any transition to or from BAD.
REQ-021 Short yellow SHALL be raised on leaving Y1 or Y2 with DWELL < MIN_YLW-1, meaning the yellow held fewer than MIN_YLW sampled cycles.
REQ-022 Timeout SHALL be raised when DWELL reaches MAX_DWELL while PHASE is in G1, Y1, G2 or Y2. AR, FLASH and BAD are exempt.
REQ-023 Same-cycle fault priority SHALL be conflict > illegal > sequence > short yellow > timeout.
REQ-024 FCODE SHALL latch the first fault and hold it; FAULT SHALL stay 1 until CLR; later faults SHALL NOT overwrite FCODE.
REQ-025 After a fault, PHASE and DWELL tracking SHALL continue.
REQ-026 On a PHASE change, DWELL SHALL load 0 and CHG SHALL be 1 for one cycle.
REQ-027 Otherwise DWELL SHALL increment and saturate at 2^DWELL_W-1 without wrap.
REQ-028 A phase change in the same cycle that DWELL reaches MAX_DWELL SHALL not raise timeout.

Reset
REQ-029 While CLR=1: PHASE=0 (AR), DWELL=0, CHG=0, FAULT=0, FCODE=0, and the lamp sample register is cleared to the AR vector.
REQ-030 CLR SHALL override all other activity, including asserting mid-phase or in the same cycle as a fault.
REQ-031 The first post-reset decode SHALL be checked as a transition from AR.

Structure
REQ-032 A shared package traffic_mon_pkg SHALL hold the phase codes, fault codes and the legal-transition table.
REQ-033 One combinational sub-module lamp_decode SHALL map the six lamp bits plus FM to phase code, conflict and illegal; all state SHALL live in the top module.

Verification
REQ-034 Scenario: CLR 2 cycles, then G1×10, Y1×3, AR×2, G2×10, Y2×3, G1 -> CHG pulses at each change; DWELL peaks 9, 2, 1, 9, 2; FAULT=0.
REQ-035 Scenario: during G1, assert GRN1=1 and GRN2=1 for 1 cycle -> FCODE=1; FAULT stays 1 through subsequent legal phases until CLR.
REQ-036 Scenario: G1 then G2 directly -> FCODE=3. Separately, G1 then Y1 held 2 cycles then AR with MIN_YLW=3 -> FCODE=4.
REQ-037 Scenario: hold G2 for 201 cycles with MAX_DWELL=200 -> FCODE=5 one cycle after DWELL=200. Repeat holding AR for 300 cycles -> no fault, DWELL saturates at 255.
REQ-038 Scenario: FM=1 with all lamps off, then YLW1=YLW2=1 alternating -> PHASE=5, no fault. Then FM=0 with AR -> legal. Then FM=0 with all lamps off -> FCODE=2.
REQ-039 Scenario: CLR asserted mid-Y1 at DWELL=1 -> next cycle PHASE=0, DWELL=0, FAULT=0. Subsequent G1 -> legal.
